// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S sample path: sample width, stereo
// pair layout, feeder FSM states and the default frame length.
package i2s_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int DEF_FRAME_CLKS = 256;  // 12.288 MHz / 48 kHz

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } feed_state_t;

endpackage

// File: rtl/stereo_sync_fifo.sv
// Single-clock FIFO of stereo pairs ({left, right}); DEPTH must be a power of
// two so the pointers wrap naturally. `ready` is registered from the next level.
module stereo_sync_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic [2*SAMPLE_W-1:0]   push_data,
    input  logic                    pop,
    output logic [2*SAMPLE_W-1:0]   pop_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty,
    output logic                    ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [2*SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [AW:0]           count_nxt;
    logic                  do_push;
    logic                  do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == DEPTH_L);
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (!do_push && do_pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            // A pop that frees space only re-opens ready on the following cycle.
            ready <= (count_nxt != DEPTH_L);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/i2s_sample_feeder.sv
// Buffers stereo pairs and releases one per audio frame to the I2S transmitter.
// Build option I2S_FEED_HOLD_LAST_EN: repeat the last pair on underrun instead of silence.
module i2s_sample_feeder
    import i2s_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int FRAME_CLKS = DEF_FRAME_CLKS,
    parameter int VALID_CLKS = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [SAMPLE_W-1:0]     in_left,
    input  logic [SAMPLE_W-1:0]     in_right,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [SAMPLE_W-1:0]     left_sample,
    output logic [SAMPLE_W-1:0]     right_sample,
    output logic                    sample_valid,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [15:0]             underrun_cnt,
    output logic                    running,
    output logic [1:0]              dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FRAME_CLKS);
    localparam logic [AW:0]   HALF = (AW+1)'(DEPTH / 2);
    localparam logic [CW-1:0] LAST = CW'(FRAME_CLKS - 1);
    localparam logic [CW-1:0] VLIM = CW'(VALID_CLKS);

    feed_state_t            state;
    feed_state_t            state_nxt;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   tick;
    logic                   sv_nxt;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [2*SAMPLE_W-1:0]  fifo_data;

    // Source handshake: a pair transfers on a clk edge where in_valid && in_ready;
    // the source holds in_left/in_right stable while in_valid is high and unaccepted.
    assign fifo_push = in_valid && in_ready && !fifo_full;
    assign fifo_pop  = tick && !fifo_empty;

    stereo_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data ({in_left, in_right}),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .ready     (in_ready)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable) state_nxt = ST_PRIME;
            ST_PRIME: begin
                if (!enable)
                    state_nxt = ST_IDLE;
                else if (fifo_level >= HALF)
                    state_nxt = ST_RUN;
            end
            ST_RUN:   if (!enable) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The PRIME->RUN transition is itself a tick so the first pair leaves at once.
    always_comb begin
        tick = enable && (((state == ST_PRIME) && (fifo_level >= HALF)) ||
                          ((state == ST_RUN) && (cnt == LAST)));
        cnt_nxt = '0;
        if ((state == ST_RUN) && enable)
            cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
        sv_nxt    = (state_nxt == ST_RUN) && (cnt_nxt < VLIM);
        running   = (state == ST_RUN);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            sample_valid <= 1'b0;
            left_sample  <= '0;
            right_sample <= '0;
            underrun_cnt <= '0;
        end else begin
            cnt          <= cnt_nxt;
            sample_valid <= sv_nxt;
            if (tick) begin
                if (!fifo_empty) begin
                    left_sample  <= fifo_data[2*SAMPLE_W-1:SAMPLE_W];
                    right_sample <= fifo_data[SAMPLE_W-1:0];
                end else begin
                    if (underrun_cnt != 16'hFFFF)
                        underrun_cnt <= underrun_cnt + 1'b1;
`ifdef I2S_FEED_HOLD_LAST_EN
                    // Outputs already hold the last popped pair (or 0 since reset).
                    left_sample  <= left_sample;
                    right_sample <= right_sample;
`else
                    left_sample  <= '0;
                    right_sample <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Self-checking bench for i2s_sample_feeder: directed scenarios plus random traffic
// compared every cycle against a queue-based frame model.
module tb_i2s_sample_feeder;
    import i2s_pkg::*;

    localparam int DEPTH = 16;
    localparam int FRAME = 256;
    localparam int VALID = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] in_left = '0;
    logic [15:0] in_right = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic        sample_valid;
    logic [4:0]  fifo_level;
    logic [15:0] underrun_cnt;
    logic        running;
    logic [1:0]  dbg_state;

    i2s_sample_feeder #(.DEPTH(DEPTH), .FRAME_CLKS(FRAME), .VALID_CLKS(VALID)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .in_left      (in_left),
        .in_right     (in_right),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt),
        .running      (running),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    bit          m_rdy;
    int          m_mode;      // 0 idle, 1 priming, 2 running
    int          m_phase;
    int          m_sv_left;
    logic [15:0] m_l, m_r;
    int          m_ucnt;
    int          cyc = 0;
    bit          log_rises = 0;
    bit          sv_prev = 0;
    int          rise_q[$];
    logic [31:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rdy = 0; m_mode = 0; m_phase = 0; m_sv_left = 0;
        m_l = '0; m_r = '0; m_ucnt = 0;
    endtask

    // One clock edge of the frame rules, using the inputs present at the edge.
    task automatic model_edge();
        bit push, tick;
        logic [31:0] p;
        push = in_valid && m_rdy;
        tick = enable && ((m_mode == 1 && exp_q.size() >= DEPTH/2) ||
                          (m_mode == 2 && m_phase == FRAME-1));
        if (tick) begin
            if (exp_q.size() > 0) begin
                p = exp_q.pop_front();
                m_l = p[31:16];
                m_r = p[15:0];
            end else begin
                if (m_ucnt < 65535) m_ucnt++;
`ifndef I2S_FEED_HOLD_LAST_EN
                m_l = '0;
                m_r = '0;
`endif
            end
        end
        if (push) exp_q.push_back({in_left, in_right});
        m_rdy = (exp_q.size() < DEPTH);
        if (!enable) begin
            m_mode = 0; m_phase = 0; m_sv_left = 0;
        end else begin
            case (m_mode)
                0: m_mode = 1;
                1: if (tick) begin m_mode = 2; m_phase = 0; end
                default: m_phase = (m_phase + 1) % FRAME;
            endcase
            if (tick) m_sv_left = VALID;
            else if (m_sv_left > 0) m_sv_left--;
        end
    endtask

    task automatic check_all();
        check("fifo_level",   fifo_level,   exp_q.size());
        check("in_ready",     in_ready,     m_rdy);
        check("sample_valid", sample_valid, m_sv_left > 0);
        check("left_sample",  left_sample,  m_l);
        check("right_sample", right_sample, m_r);
        check("underrun_cnt", underrun_cnt, m_ucnt);
        check("running",      running,      m_mode == 2);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_all();
        if (log_rises && sample_valid && !sv_prev) begin
            rise_q.push_back(cyc);
            got_q.push_back({left_sample, right_sample});
        end
        sv_prev = sample_valid;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;
        check("rst_in_ready_first", in_ready, 1'b0);
        step();
        check("rst_in_ready_after", in_ready, 1'b1);
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        bit hs;
        bit done = 0;
        in_valid = 1'b1; in_left = l; in_right = r;
        for (int t = 0; t < 600 && !done; t++) begin
            hs = in_ready;
            step();
            if (hs) done = 1;
        end
        in_valid = 1'b0;
        if (!done) check("push_timeout", 0, 1);
    endtask

    task automatic wait_sv(input int bound);
        bit seen = 0;
        for (int t = 0; t < bound && !seen; t++) begin
            step();
            if (sample_valid) seen = 1;
        end
        if (!seen) check("wait_sv_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        bit hs;
        logic [31:0] exp_pair;

        model_reset();

        // Prime with 8 ordered pairs, then starve: 8 data frames, then underruns.
        do_reset();
        for (int i = 1; i <= 8; i++)
            push_pair(16'(i), 16'h8000 | 16'(i));
        check("prime_level", fifo_level, 8);
        log_rises = 1;
        enable = 1'b1;
        repeat (12*FRAME + 20) step();
        log_rises = 0;
        check("frames_seen", rise_q.size(), 13);
        for (int k = 1; k < rise_q.size(); k++)
            check("frame_spacing", rise_q[k] - rise_q[k-1], FRAME);
        for (int k = 0; k < got_q.size(); k++) begin
            if (k < 8) exp_pair = {16'(k+1), 16'h8000 | 16'(k+1)};
`ifdef I2S_FEED_HOLD_LAST_EN
            else exp_pair = 32'h0008_8008;
`else
            else exp_pair = 32'h0;
`endif
            check("frame_pair", got_q[k], exp_pair);
        end
        check("underruns_A", underrun_cnt, 5);

        // Push into the empty FIFO on the tick cycle: underrun now, pair next frame.
        begin
            bit found = 0;
            for (int t = 0; t < 400 && !found; t++) begin
                if (m_mode == 2 && m_phase == FRAME-1) found = 1;
                else step();
            end
            if (!found) check("tick_align_timeout", 0, 1);
        end
        in_valid = 1'b1; in_left = 16'h1234; in_right = 16'h5678;
        step();
        in_valid = 1'b0;
        check("same_tick_underrun", underrun_cnt, 6);
        check("same_tick_level", fifo_level, 1);
        repeat (FRAME) step();
        check("same_tick_next_pair", {left_sample, right_sample}, 32'h1234_5678);
        check("same_tick_sv", sample_valid, 1'b1);

        // Drop enable mid-pulse, then re-prime.
        wait_sv(2*FRAME);
        step();
        enable = 1'b0;
        step();
        check("drop_sv", sample_valid, 1'b0);
        check("drop_running", running, 1'b0);
        check("drop_state_idle", dbg_state, 2'd0);
        enable = 1'b1;
        repeat (20) step();
        check("reprime_hold", sample_valid, 1'b0);
        for (int i = 0; i < 8; i++)
            push_pair(16'($urandom), 16'($urandom));
        repeat (3*FRAME) step();

        // Hold in_valid for 20 cycles while idle: exactly 16 accepted.
        do_reset();
        acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_left = 16'($urandom); in_right = 16'($urandom);
            hs = in_ready;
            step();
            if (hs) acc++;
        end
        in_valid = 1'b0;
        check("fill_accepted", acc, 16);
        check("fill_level", fifo_level, 16);
        check("fill_ready", in_ready, 1'b0);
        enable = 1'b1;
        repeat (17*FRAME + 4) step();
        check("fill_drained", fifo_level, 0);

        // Random traffic with occasional enable toggles.
        do_reset();
        for (int t = 0; t < 9000; t++) begin
            if ($urandom_range(0, 1499) == 0) enable = ~enable;
            if (t == 50) enable = 1'b1;
            in_valid = ($urandom_range(0, 199) < 2);
            in_left = 16'($urandom); in_right = 16'($urandom);
            step();
        end
        in_valid = 1'b0;

        // Asynchronous reset in the middle of a valid pulse.
        enable = 1'b1;
        for (int i = 0; i < 8; i++)
            push_pair(16'($urandom), 16'($urandom));
        wait_sv(3*FRAME);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_sv", sample_valid, 1'b0);
        check("arst_left", left_sample, 16'h0);
        check("arst_right", right_sample, 16'h0);
        check("arst_level", fifo_level, 0);
        check("arst_underrun", underrun_cnt, 0);
        check("arst_running", running, 1'b0);
        check("arst_ready", in_ready, 1'b0);
        do_reset();
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2s_sample_feeder.md
# i2s_sample_feeder

Stereo sample buffer and frame-rate pacer that sits directly upstream of the I2S transmitter. Accepts 16-bit left/right pairs from the audio source over a valid/ready handshake, buffers them in a small FIFO, and releases exactly one pair per audio frame period. Each release drives `left_sample`/`right_sample` and a multi-cycle `sample_valid` into the transmitter. Underruns are detected, counted and filled so the transmitter never stalls.

## Interface
- `DEPTH`, 16: FIFO depth in stereo pairs; power of two, ≥4.
- `FRAME_CLKS`, 256: `clk` cycles per frame (12.288 MHz / 48 kHz); must be ≥136.
- `VALID_CLKS`, 4: length of each `sample_valid` assertion in cycles; 1..FRAME_CLKS-1.
- `clk` in 1: master clock, same clock as the transmitter.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; run the pacer.
- `in_left` in 16: source left sample, two's complement.
- `in_right` in 16: source right sample.
- `in_valid` in 1: source pair valid.
- `in_ready` out 1: FIFO can accept a pair.
- `left_sample` out 16: pair to transmitter.
- `right_sample` out 16: pair to transmitter.
- `sample_valid` out 1: pair valid to transmitter.
- `fifo_level` out $clog2(DEPTH)+1: pairs currently stored.
- `underrun_cnt` out 16: saturating count of frames with no data.
- `running` out 1: high in RUN state.

## Operation
- Reset values: `in_ready`=0 in the first cycle after reset release, 1 thereafter while not full. All other outputs are 0. FIFO is empty, state is IDLE, and the frame counter is 0.
- Push occurs when `in_valid && in_ready`. `in_ready` = (`fifo_level` < DEPTH), registered from the current level.
  - A pop in the same cycle does not re-open `in_ready` until the next cycle.
- States:
  - IDLE: counter held at 0, no pops; `sample_valid`=0. Pushes are still accepted. Moves to PRIME when `enable`=1.
  - PRIME: waits until `fifo_level` ≥ DEPTH/2, then goes to RUN with the counter at 0. Returns to IDLE if `enable`=0.
  - RUN: counter counts 0..FRAME_CLKS-1 and wraps. Goes to IDLE when `enable`=0, taking effect on the next cycle; the counter clears and `sample_valid` is forced to 0 immediately.
- Frame tick: in RUN when the counter = FRAME_CLKS-1, and also on the PRIME→RUN transition cycle.
  - If the FIFO is non-empty: pop and load the pair into `left_sample`/`right_sample`.
  - If the FIFO is empty: underrun. Load the fill value (see Configuration) and increment `underrun_cnt`, which saturates at 0xFFFF.
- There is no fall-through: a push and a tick on an empty FIFO in the same cycle is an underrun, and the pushed pair is kept for the next frame.
- `sample_valid` goes high the cycle after a tick for exactly VALID_CLKS cycles. Sample outputs stay stable for the whole frame.
- FIFO pointers wrap modulo DEPTH. `fifo_level` counts push and pop with simultaneous push+pop leaving it unchanged.
- `underrun_cnt` is cleared only by reset.

## Timing
- Latency from input to output: the first pair reaches the outputs 1 cycle after the PRIME→RUN tick. `sample_valid` rises in that same cycle.
- Steady state: rising edges of `sample_valid` are exactly FRAME_CLKS cycles apart.
- `fifo_level` and `in_ready` update 1 cycle after the handshake or pop.
- Asynchronous reset mid-frame clears everything immediately, including an in-progress `sample_valid` pulse. FIFO contents are discarded.

## Configuration
- `I2S_FEED_HOLD_LAST_EN` defined: on underrun, the outputs repeat the last successfully popped pair, or 0 if none has been popped since reset.
- `I2S_FEED_HOLD_LAST_EN` undefined: on underrun, the outputs are loaded with 0 (silence).
- `sample_valid` and `underrun_cnt` behave identically in both builds.

## Structure
- Package `i2s_pkg`:
  - `SAMPLE_W`=16
  - stereo pair typedef (left, right)
  - feeder state enum (IDLE, PRIME, RUN)
  - default FRAME_CLKS constant, shared with the transmitter.
- Sub-module `stereo_sync_fifo`: single-clock FIFO of pairs with push, pop, level and full/empty outputs. The pacer FSM, counter and output registers stay in the top module.

## Test plan
- Push 8 pairs (0x0001/0x8001 … 0x0008/0x8008) with DEPTH=16, then raise `enable` → PRIME→RUN on the cycle `fifo_level` reaches 8. Outputs follow in order 0x0001/0x8001 first, with `sample_valid` high 4 cycles every 256 cycles.
- Hold `in_valid` high through 20 pushes while not running → `in_ready` falls at level 16, exactly 16 pairs are accepted, and none are lost.
- Prime with 8 pairs, then stop feeding → 8 frames of data, then frames 9+ are underruns. `underrun_cnt` goes 1, 2, 3…. Outputs read 0x0008/0x8008 (HOLD_LAST_EN) or 0/0 (undefined).
- Assert an empty-FIFO push at the same cycle as a tick → that frame is an underrun and the next frame outputs the pushed pair.
- Drop `enable` mid-pulse → `sample_valid` is 0 the next cycle and the state is IDLE. Re-enable → re-primes before output resumes.
- Pulse `reset_n` low asynchronously mid-frame → all outputs 0 immediately, `fifo_level`=0, `underrun_cnt`=0.
